stream_burst_source: RTL
========================

Name: stream_burst_source

Overview:
- Valid/ready stream transmitter. Accepts one burst command at a time on a command handshake, then drives an arithmetic data sequence downstream.
- Feeds single_stage_pipeline instances and any other valid/ready sink in the datapath.
- Used as the traffic source for pipeline chains in both functional datapaths and bring-up.
- Obeys the stream rules: data and last are held stable under backpressure, and the block never withdraws valid.

Parameters:
- DATA_WIDTH, 32, width of cmd_base, cmd_step and out_data.
- LEN_WIDTH, 8, width of cmd_len and the internal remaining-beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  burst command offered.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_base  input  DATA_WIDTH  first data value of the burst.
- cmd_step  input  DATA_WIDTH  increment added after each beat.
- cmd_len  input  LEN_WIDTH  number of beats; 0 = empty burst.
- out_valid  output  1  beat available.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_WIDTH  current beat data.
- out_last  output  1  current beat is the final beat of the burst.
- busy  output  1  burst in progress (state != IDLE).
- done  output  1  single-cycle pulse when a burst completes.

Behaviour:
- Reset: rst sampled high at a clock edge forces the following values after that edge.
  - state=IDLE
  - out_valid=0, out_data=0, out_last=0
  - busy=0, done=0
  - remaining=0, step register=0
- Reset mid-burst abandons the burst with no done pulse. Reset dominates all other events in the same cycle.
- Handshakes: cmd_fire = cmd_valid && cmd_ready; beat_fire = out_valid && out_ready.
- States:
  - IDLE: waiting for a command.
  - SEND: emitting beats.
  - FLUSH: one cycle used for a zero-length burst.
- cmd_ready is combinational: (state==IDLE) || (state==SEND && beat_fire && out_last). This allows back-to-back bursts with no bubble. cmd_ready must not depend on cmd_valid.
- IDLE + cmd_fire, cmd_len>0:
  - Next cycle: state=SEND, out_valid=1, out_data=cmd_base, remaining=cmd_len, out_last=(cmd_len==1).
  - cmd_step is latched.
  - Latency from command accept to first beat: 1 cycle.
- IDLE + cmd_fire, cmd_len==0: next cycle state=FLUSH, out_valid stays 0. FLUSH always returns to IDLE and asserts done for that one cycle. cmd_ready=0 while in FLUSH.
- SEND + beat_fire, not last: out_data <= out_data + step (mod 2^DATA_WIDTH, carry discarded); remaining <= remaining-1; out_last <= (remaining==2).
- SEND + beat_fire, last, no cmd_fire: next cycle IDLE, out_valid=0, done=1 for one cycle. out_data holds its last value (don't-care while out_valid=0).
- SEND + beat_fire, last, with cmd_fire: done=1 next cycle and the new burst loads exactly as from IDLE.
  - If the new cmd_len==0, go to FLUSH; done then pulses on two consecutive cycles.
- SEND with out_valid && !out_ready: out_valid, out_data, out_last and remaining are held unchanged. The block does not deassert valid until the beat is accepted.
- cmd_* inputs are don't-care when cmd_valid=0. The inputs cmd_base, cmd_step and cmd_len are sampled only on cmd_fire.
- busy=1 in SEND and FLUSH.
- Maximum burst length: 2^LEN_WIDTH-1 beats.

Test Plan:
- base=0x10, step=1, len=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles starting 1 cycle after accept; out_last only on 0x13; done pulses the cycle after 0x13 fires.
- base=0x100, step=4, len=3, out_ready low for 3 cycles while beat 0x104 is shown -> 0x104 held with out_valid=1 throughout; sequence completes 0x100,0x104,0x108; no beat dropped or duplicated.
- len=0 command -> out_valid never asserted; busy=1 for one cycle; done pulses 2 cycles after accept; cmd_ready=1 again afterwards.
- Second command (base=0xA0, len=2) held valid during the last beat of a len=2 burst at 0x00 -> accepted that cycle; stream 0x00,0x01,0xA0,0xA1 with no idle cycle; done pulses after the 0x01 and 0xA1 beats.
- base=0xFFFFFFFE, step=1, len=3 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 with out_last on 0x0.
- rst pulsed during beat 2 of a len=8 burst -> next cycle out_valid=0, busy=0, done=0, cmd_ready=1; a fresh command afterwards runs a full correct burst.

Source files
------------

// File: rtl/stream_burst_source_if.sv
// Command and output stream signals of the burst source.
// The master view belongs to the source; the slave view belongs to whatever drives commands and sinks beats.
interface stream_burst_source_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_base;
    logic [DATA_WIDTH-1:0] cmd_step;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        input  cmd_valid, cmd_base, cmd_step, cmd_len, out_ready,
        output cmd_ready, out_valid, out_data, out_last
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_step, cmd_len, out_ready,
        input  cmd_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_burst_source.sv
// Valid/ready burst source: takes one {base, step, len} command at a time and streams base, base+step, ...
// A new command can be taken on the cycle the final beat is accepted, so bursts run back to back.
module stream_burst_source #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    stream_burst_source_if.master  bus,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic                  out_last_q;
    logic                  out_last_d;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [LEN_WIDTH-1:0]  remaining_d;
    logic [DATA_WIDTH-1:0] step_q;
    logic [DATA_WIDTH-1:0] step_d;
    logic                  done_q;
    logic                  done_d;

    logic                  cmd_ready;
    logic                  cmd_fire;
    logic                  beat_fire;
    logic                  cmd_empty;

    // cmd_ready deliberately ignores cmd_valid so the command side never sees a combinational loop.
    assign beat_fire = out_valid_q && bus.out_ready;
    assign cmd_ready = (state == IDLE) || ((state == SEND) && beat_fire && out_last_q);
    assign cmd_fire  = bus.cmd_valid && cmd_ready;
    assign cmd_empty = (bus.cmd_len == '0);

    always_comb begin
        state_next  = state;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        remaining_d = remaining_q;
        step_d      = step_q;
        done_d      = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_empty) begin
                        state_next  = FLUSH;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        remaining_d = '0;
                    end else begin
                        state_next  = SEND;
                        out_valid_d = 1'b1;
                        out_data_d  = bus.cmd_base;
                        out_last_d  = (bus.cmd_len == LEN_WIDTH'(1));
                        remaining_d = bus.cmd_len;
                        step_d      = bus.cmd_step;
                    end
                end
            end

            SEND: begin
                if (beat_fire) begin
                    if (out_last_q) begin
                        done_d = 1'b1;
                        // Final beat accepted: either chain straight into the next command or go idle.
                        if (cmd_fire && !cmd_empty) begin
                            state_next  = SEND;
                            out_valid_d = 1'b1;
                            out_data_d  = bus.cmd_base;
                            out_last_d  = (bus.cmd_len == LEN_WIDTH'(1));
                            remaining_d = bus.cmd_len;
                            step_d      = bus.cmd_step;
                        end else if (cmd_fire) begin
                            state_next  = FLUSH;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            remaining_d = '0;
                        end else begin
                            state_next  = IDLE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            remaining_d = '0;
                        end
                    end else begin
                        out_data_d  = out_data_q + step_q;
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                        out_last_d  = (remaining_q == LEN_WIDTH'(2));
                    end
                end
            end

            FLUSH: begin
                state_next = IDLE;
                done_d     = 1'b1;
            end

            default: begin
                state_next  = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            remaining_q <= '0;
            step_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_next;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            remaining_q <= remaining_d;
            step_q      <= step_d;
            done_q      <= done_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state != IDLE);
    assign done          = done_q;

endmodule
